matrix_key_scan: RTL and testbench
==================================

# matrix_key_scan

Row-scanning reader for a 4x4 matrix keypad, the input-side counterpart of the multiplexed seven-segment scan driver. It drives one keypad row low at a time and samples the four column lines through a synchronizer. It debounces the first pressed key it finds and reports it as a 4-bit key code with a single-cycle strobe plus a held-down level. Its outputs feed the counter and display logic (for example, a digit entry that is then decoded onto the segments).

## Interface
- `SCAN_DIV`, default 50_000: clk cycles per scan tick (row dwell and sample period); must be ≥ 4.
- `DEBOUNCE_TICKS`, default 20: consecutive consistent tick samples required to accept a press or a release; must be ≥ 1.
- `clk` in 1: system clock.
- `rst` in 1: reset; synchronous, active-high.
- `key_col_in` in 4: keypad columns, externally pulled up; low means pressed on the driven row; asynchronous.
- `key_row_out` out 4: row drive, one-cold (exactly one bit low).
- `key_code` out 4: last accepted key, encoded {row[1:0], col[1:0]}.
- `key_valid` out 1: one-cycle pulse when a press is accepted.
- `key_down` out 1: high from press acceptance until release acceptance.

## Operation
- **Input synchronizer:** two-flop synchronizer on `key_col_in`, producing `col_s`.
- **Tick generator:**
  - Divider counts 0..SCAN_DIV-1 and wraps.
  - `tick` is high on the count SCAN_DIV-1.
  - Every sample below is taken from `col_s` on a `tick` cycle.
- **States:** SCAN, DEBOUNCE, HOLD, RELEASE.
- **SCAN:**
  - On a tick with `col_s` == 4'b1111: advance the row; `key_row_out` rotates 1110→1101→1011→0111→1110.
  - On a tick with any `col_s` bit low:
    - Latch the current row index.
    - Latch the lowest-index low column.
    - Clear the debounce count to 1 and go to DEBOUNCE. The row stays driven.
- **DEBOUNCE (row frozen):**
  - Each tick where the latched column is still low increments the count.
  - When the count reaches DEBOUNCE_TICKS:
    - Load `key_code`.
    - Pulse `key_valid`.
    - Set `key_down`.
    - Go to HOLD.
  - A tick with the latched column high returns to SCAN and advances to the next row.
  - With DEBOUNCE_TICKS = 1, acceptance happens on the detecting tick itself: go directly SCAN→HOLD.
- **HOLD (row frozen):**
  - A tick with the latched column high clears the count to 1 and goes to RELEASE.
  - Other columns are ignored, so no second key is reported while one is held.
- **RELEASE:**
  - Each tick with the latched column high increments the count.
  - When the count reaches DEBOUNCE_TICKS: clear `key_down` and go to SCAN, advancing the row.
  - A tick with the latched column low returns to HOLD.
- **Simultaneous keys on one row:** the lowest column wins.
- **Keys on different rows:** the first row scanned wins.
- **Reset mid-operation:** any state returns to SCAN with all outputs at their reset values. No `key_valid` is emitted during or after reset until a full debounce completes.

## Timing
- **Reset values:**
  - `key_row_out` = 4'b1110.
  - `key_code` = 4'h0.
  - `key_valid` = 0.
  - `key_down` = 0.
  - Divider = 0.
  - State = SCAN.
- **Synchronizer latency:** 2 clk from the pin to `col_s`.
- **Row settling:** the row changes on the cycle after a tick. The next sample is SCAN_DIV cycles later, which covers settling plus the synchronizer depth.
- **Press output timing:** `key_valid`, `key_code` and the rising edge of `key_down` all register on the clk edge after the accepting tick. `key_valid` is high for exactly 1 cycle.
- **Release output timing:** `key_down` falls on the clk edge after the accepting release tick.
- **`key_code` hold:** `key_code` holds its value until the next accepted press.
- **Minimum press-to-valid latency:** press sampled on its row at tick N → `key_valid` one cycle after tick N+DEBOUNCE_TICKS-1.
- **Divider:** free-running in every state and never reset by state changes.

## Structure
- Shared header `keypad_defs.vh` holds:
  - State encodings (SCAN=2'd0, DEBOUNCE=2'd1, HOLD=2'd2, RELEASE=2'd3).
  - The row reset pattern 4'b1110.
  - The idle column value 4'b1111.
- Sub-module `tick_gen` (parameter DIV; ports clk, rst, tick) provides the divider; it is reusable by the display scan.
- Top level contains the synchronizer, row rotator, FSM, debounce counter (width $clog2(DEBOUNCE_TICKS+1)) and output registers.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_TICKS=3.
- **Idle:** columns held 4'b1111 for 64 cycles → `key_row_out` cycles 1110,1101,1011,0111, changing every 4 cycles; `key_valid` never asserted.
- **Clean press:** col1 held low only while row 2 (1011) is driven, held for 40 cycles → exactly one `key_valid`, `key_code` = 4'h9, `key_down` = 1 until release.
- **Bounce:** col0 on row 0 low for 1 tick, high for 1 tick, then low steadily → no pulse on the first contact; one pulse with `key_code` = 4'h0 after 3 steady ticks.
- **Release debounce:** key 4'h9 held, then released with a 1-tick glitch back low:
  - `key_down` stays 1 through the glitch.
  - `key_down` falls only after 3 consecutive high ticks.
  - Scanning resumes at row 3.
- **Multi-key:** cols 2 and 3 low on row 1 together → `key_code` = 4'h6. A key pressed on row 3 during HOLD produces no `key_valid`.
- **Reset mid-debounce:** `rst` pulsed for 1 cycle during DEBOUNCE → all outputs return to reset values next cycle and no `key_valid` appears until a fresh 3-tick debounce completes.

Source files
------------

// File: rtl/matrix_key_scan_pkg.sv
// Shared definitions for the keypad scanner: FSM states, row/column idle
// patterns and the column priority encoder.
package matrix_key_scan_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ROW_RESET = 4'b1110;
    localparam logic [3:0] COL_IDLE  = 4'b1111;

    // Lowest-index column that is pulled low; 0 when none are.
    function automatic logic [1:0] first_low(input logic [3:0] col);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/matrix_key_scan_tick_gen.sv
// Free-running divider: pulses tick for one cycle every DIV clocks.
module tick_gen #(
    parameter int DIV = 50_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)                count <= '0;
        else if (count == LAST) count <= '0;
        else                    count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 keypad row scanner with press/release debounce; reports the first
// key found as {row, col} with a one-cycle strobe and a held-down level.
module matrix_key_scan
    import matrix_key_scan_pkg::*;
#(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_col_in,
    output logic [3:0] key_row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);
    localparam int          CW       = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_TICKS);
    localparam bit          ONE_TICK = (DEBOUNCE_TICKS == 1);

    logic [3:0]    col_m, col_s;
    logic          tick;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [1:0]    row_idx, lat_col, col_sel;
    logic          still_low, advance, accept, released, latch;

    tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign cnt_inc   = cnt + 1'b1;
    assign still_low = ~col_s[lat_col];
    assign col_sel   = latch ? first_low(col_s) : lat_col;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        advance   = 1'b0;
        accept    = 1'b0;
        released  = 1'b0;
        latch     = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (col_s != COL_IDLE) begin
                        latch   = 1'b1;
                        cnt_nxt = CNT_ONE;
                        if (ONE_TICK) begin
                            accept    = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (still_low) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            accept    = 1'b1;
                            state_nxt = HOLD;
                        end
                    end else begin
                        state_nxt = SCAN;
                        advance   = 1'b1;
                    end
                end
                HOLD: begin
                    // Only the latched column matters; other keys are masked.
                    if (!still_low) begin
                        cnt_nxt = CNT_ONE;
                        if (ONE_TICK) begin
                            released  = 1'b1;
                            advance   = 1'b1;
                            state_nxt = SCAN;
                        end else begin
                            state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!still_low) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            released  = 1'b1;
                            advance   = 1'b1;
                            state_nxt = SCAN;
                        end
                    end else begin
                        state_nxt = HOLD;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_m       <= COL_IDLE;
            col_s       <= COL_IDLE;
            state       <= SCAN;
            cnt         <= '0;
            lat_col     <= 2'd0;
            row_idx     <= 2'd0;
            key_row_out <= ROW_RESET;
            key_code    <= 4'h0;
            key_valid   <= 1'b0;
            key_down    <= 1'b0;
        end else begin
            col_m     <= key_col_in;
            col_s     <= col_m;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            key_valid <= accept;
            if (latch) lat_col <= col_sel;
            if (advance) begin
                row_idx     <= row_idx + 2'd1;
                key_row_out <= {key_row_out[2:0], key_row_out[3]};
            end
            if (accept) begin
                key_code <= {row_idx, col_sel};
                key_down <= 1'b1;
            end else if (released) begin
                key_down <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_key_scan.sv
// Bench for matrix_key_scan: keypad model driving the columns, a tick-level
// behavioural reference checked every cycle, table vectors and corner cases.
module tb_matrix_key_scan;
    localparam int DIV = 4;
    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_col_in;
    logic [3:0] key_row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] pressed = 16'h0;   // bit r*4+c = key at row r, col c held
    logic [3:0]  pins;
    int          checks = 0;
    int          errors = 0;
    int          vcount = 0;
    bit          chk_en = 1'b0;

    matrix_key_scan #(.SCAN_DIV(DIV), .DEBOUNCE_TICKS(DEB)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_col_in  (key_col_in),
        .key_row_out (key_row_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_down    (key_down)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key shorts its column to a row driven low.
    always_comb begin
        pins = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_row_out[r] == 1'b0 && pressed[r*4+c]) pins[c] = 1'b0;
    end
    assign key_col_in = pins;

    // Reference: state held here is what the outputs should be after the
    // coming clock edge; inputs are read at the negedge where they are stable.
    int         m_div, m_row, m_mode, m_streak, m_col;
    logic [3:0] m_s1, m_s2, m_code, m_rowpat;
    logic       m_valid, m_down;

    always @(negedge clk) begin
        m_rowpat = 4'hF ^ (4'b0001 << m_row);
        if (chk_en) begin
            checks++;
            if ({key_row_out, key_code, key_valid, key_down} !==
                {m_rowpat, m_code, m_valid, m_down}) begin
                errors++;
                $display("FAIL model_cycle t=%0t got row=%b code=%h valid=%b down=%b want row=%b code=%h valid=%b down=%b",
                         $time, key_row_out, key_code, key_valid, key_down,
                         m_rowpat, m_code, m_valid, m_down);
            end
        end
        if (key_valid === 1'b1) vcount++;
        if (rst) begin
            m_div = 0; m_row = 0; m_mode = 0; m_streak = 0; m_col = 0;
            m_s1 = 4'hF; m_s2 = 4'hF; m_code = 4'h0; m_valid = 1'b0; m_down = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_div == DIV - 1) begin
                case (m_mode)
                    0: if (m_s2 != 4'hF) begin
                           for (int i = 3; i >= 0; i--) if (!m_s2[i]) m_col = i;
                           m_streak = 1;
                           m_mode = 1;
                       end else m_row = (m_row + 1) % 4;
                    1: if (!m_s2[m_col]) m_streak++;
                       else begin m_mode = 0; m_row = (m_row + 1) % 4; end
                    2: if (m_s2[m_col]) begin m_streak = 1; m_mode = 3; end
                    default: if (m_s2[m_col]) m_streak++; else m_mode = 2;
                endcase
                if (m_mode == 1 && m_streak >= DEB) begin
                    m_code = 4'((m_row << 2) + m_col);
                    m_valid = 1'b1; m_down = 1'b1; m_mode = 2;
                end else if (m_mode == 3 && m_streak >= DEB) begin
                    m_down = 1'b0; m_mode = 0; m_row = (m_row + 1) % 4;
                end
            end
            m_div = (m_div + 1) % DIV;
            m_s2 = m_s1;
            m_s1 = pins;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] mask;
        int          hold;
        int          n_valid;
        logic [3:0]  code;
        logic        down;
    } vec_t;

    vec_t vecs[6];
    int   v0;
    bit   seen;

    initial begin
        vecs[0] = '{16'h0000, 64, 0, 4'h0, 1'b0};   // idle
        vecs[1] = '{16'h0200, 60, 1, 4'h9, 1'b1};   // row2 col1
        vecs[2] = '{16'h00C0, 60, 1, 4'h6, 1'b1};   // row1 cols 2+3
        vecs[3] = '{16'h0001, 60, 1, 4'h0, 1'b1};
        vecs[4] = '{16'h8000, 60, 1, 4'hF, 1'b1};
        vecs[5] = '{16'h0008, 60, 1, 4'h3, 1'b1};

        step(3);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_row", key_row_out, 4'b1110);
        chk("reset_code", key_code, 0);
        chk("reset_valid", key_valid, 0);
        chk("reset_down", key_down, 0);
        step(0);

        for (int i = 0; i < 6; i++) begin
            v0 = vcount;
            pressed = vecs[i].mask;
            step(vecs[i].hold);
            @(negedge clk);
            chk($sformatf("vec%0d_valids", i), vcount - v0, vecs[i].n_valid);
            chk($sformatf("vec%0d_code", i), key_code, vecs[i].code);
            chk($sformatf("vec%0d_down", i), key_down, vecs[i].down);
            pressed = 16'h0;
            step(40);
            chk($sformatf("vec%0d_released", i), key_down, 0);
        end

        // Key on row 3 while key 6 is held is masked.
        pressed = 16'h0040;
        step(60);
        v0 = vcount;
        pressed = 16'h2040;
        step(60);
        chk("hold_mask_valids", vcount - v0, 0);
        chk("hold_mask_code", key_code, 4'h6);
        pressed = 16'h0;
        step(40);

        // Bouncy contact on key 0.
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step(1);
            if (key_row_out == 4'b1110) seen = 1'b1;
        end
        chk("bounce_row0_reached", seen, 1);
        v0 = vcount;
        pressed = 16'h0001; step(4);
        pressed = 16'h0000; step(4);
        pressed = 16'h0001; step(60);
        chk("bounce_valids", vcount - v0, 1);
        chk("bounce_code", key_code, 4'h0);
        pressed = 16'h0;
        step(40);

        // Release with a glitch, then scanning resumes at row 3.
        pressed = 16'h0200;
        step(60);
        pressed = 16'h0000; step(4);
        pressed = 16'h0200; step(4);
        chk("glitch_down_held", key_down, 1);
        pressed = 16'h0000;
        seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            @(negedge clk);
            if (!key_down) seen = 1'b1;
        end
        chk("release_seen", seen, 1);
        chk("release_row3", key_row_out, 4'b0111);
        step(40);

        // Reset while debouncing key 5.
        pressed = 16'h0020;
        seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            @(negedge clk);
            if (m_mode == 1) seen = 1'b1;
        end
        chk("rst_debounce_reached", seen, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_row", key_row_out, 4'b1110);
        chk("rst_mid_code", key_code, 0);
        chk("rst_mid_down", key_down, 0);
        v0 = vcount;
        step(12);
        chk("rst_no_early_valid", vcount - v0, 0);
        step(60);
        chk("rst_fresh_valid", vcount - v0, 1);
        chk("rst_fresh_code", key_code, 4'h5);
        pressed = 16'h0;
        step(40);

        // Random keys against the reference model.
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 3))
                0: pressed = 16'h0;
                1: pressed = 16'(1) << $urandom_range(0, 15);
                2: pressed = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                default: pressed = 16'($urandom);
            endcase
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1; step(1); rst = 1'b0;
            end
            step($urandom_range(1, 40));
        end
        pressed = 16'h0;
        step(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
